// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_driver
// Purpose  : Initiator-side controller for a bank of WIDTH external JK
//            flip-flops. Takes a target value over a valid/ready command
//            channel, drives the minimal J/K excitation for exactly one
//            cycle, reads the bank back, retries on mismatch and reports
//            ok/error over a valid/ready response channel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        number of JK flops in the driven bank
//   MAX_RETRY    extra drive attempts after the first mismatch (0 = none)
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   cmd_valid_i  command present
//   cmd_ready_o  command accepted this cycle when valid (high only in IDLE)
//   cmd_target_i requested bank value (toggle mask for toggle commands)
//   cmd_op_i     0 = set command, 1 = toggle command (optional, see below)
//   q_i          bank outputs fed back from the same clock domain
//   j_o / k_o    registered J/K inputs to the bank
//   resp_valid_o result available
//   resp_ready_i result consumed
//   resp_err_o   1 = target not reached after all attempts
//   busy_o       high in any state other than IDLE
// Optional feature
//   Define JK_TOGGLE_CMD_EN to add cmd_op_i and toggle commands. In a toggle
//   command cmd_target_i is a mask m; J = K = m is driven and the expected
//   bank value becomes q_i ^ m. Retries always use set-style excitation.
// ============================================================================
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_target_i,
`ifdef JK_TOGGLE_CMD_EN
    input  logic             cmd_op_i,
`endif
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_err_o,
    output logic             busy_o
);

    // Retry counter is at least one bit wide even when retries are disabled.
    localparam int c_RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_target;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [WIDTH-1:0]       r_j;
    logic [WIDTH-1:0]       r_k;
    logic                   r_resp_valid;
    logic                   r_resp_err;
    logic                   r_busy;
    logic                   r_cmd_ready;

    // Excitation and expected value for a freshly accepted command, derived
    // from the bank value present on q_i in the acceptance cycle.
    logic [WIDTH-1:0]       w_acc_j;
    logic [WIDTH-1:0]       w_acc_k;
    logic [WIDTH-1:0]       w_acc_target;

    // Set-style retry excitation toward the stored expected value. Bits
    // already at their target get J = K = 0 (hold); the don't-care half of
    // each J/K pair is resolved to 0.
    logic [WIDTH-1:0]       w_retry_j;
    logic [WIDTH-1:0]       w_retry_k;
    logic                   w_match;
    logic                   w_accept;
    logic                   w_can_retry;

    always_comb begin
        w_acc_j      = ~q_i & cmd_target_i;
        w_acc_k      = q_i & ~cmd_target_i;
        w_acc_target = cmd_target_i;
`ifdef JK_TOGGLE_CMD_EN
        if (cmd_op_i) begin
            // Toggle: J = K = 1 flips exactly the masked bits.
            w_acc_j      = cmd_target_i;
            w_acc_k      = cmd_target_i;
            w_acc_target = q_i ^ cmd_target_i;
        end
`endif
    end

    assign w_retry_j   = ~q_i & r_target;
    assign w_retry_k   = q_i & ~r_target;
    assign w_match     = (q_i == r_target);
    assign w_accept    = cmd_valid_i & r_cmd_ready;
    assign w_can_retry = (r_retry < c_MAX_RETRY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_target     <= '0;
            r_retry      <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_cmd_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_target    <= w_acc_target;
                        r_j         <= w_acc_j;
                        r_k         <= w_acc_k;
                        r_retry     <= '0;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    // Excitation is a single-cycle pulse; the bank samples
                    // it on this edge, so it is removed here.
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= ST_CHECK;
                end

                ST_CHECK: begin
                    if (w_match) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_state      <= ST_RESP;
                    end else if (w_can_retry) begin
                        r_retry <= r_retry + 1'b1;
                        r_j     <= w_retry_j;
                        r_k     <= w_retry_k;
                        r_state <= ST_DRIVE;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_busy       <= 1'b0;
                        r_cmd_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_j          <= '0;
                    r_k          <= '0;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_busy       <= 1'b0;
                    r_cmd_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o  = r_cmd_ready;
    assign j_o          = r_j;
    assign k_o          = r_k;
    assign resp_valid_o = r_resp_valid;
    assign resp_err_o   = r_resp_err;
    assign busy_o       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_jk_bank_driver
// Purpose  : Self-checking bench for jk_bank_driver. Contains a model of the
//            external JK bank (with stuck and disturbance injection), a
//            table of directed vectors, hand-written corner sequences and
//            randomized commands checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_driver;

    localparam int WIDTH     = 4;
    localparam int MAX_RETRY = 2;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_target;
`ifdef JK_TOGGLE_CMD_EN
    logic             cmd_op;
`endif
    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_err;
    logic             busy;

    // Bank model controls
    logic             load_req;
    logic [WIDTH-1:0] load_val;
    logic             stuck;
    logic [WIDTH-1:0] disturb;

    int checks;
    int errors;

    jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_target_i (cmd_target),
`ifdef JK_TOGGLE_CMD_EN
        .cmd_op_i     (cmd_op),
`endif
        .q_i          (bank_q),
        .j_o          (j),
        .k_o          (k),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_err_o   (resp_err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External JK bank: Q+ = J~Q | ~K Q, optionally stuck or disturbed.
    always @(posedge clk) begin
        if (load_req)
            bank_q <= load_val;
        else if (!stuck)
            bank_q <= ((j & ~bank_q) | (~k & bank_q)) ^ disturb;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] q0;
        logic [WIDTH-1:0] t;
        bit               stk;
        logic [WIDTH-1:0] ej;
        logic [WIDTH-1:0] ek;
        bit               eerr;
        int               ecyc;
        int               epulses;
    } vec_t;

    vec_t vecs[6];

    task automatic load_bank(input logic [WIDTH-1:0] v, input bit s);
        @(negedge clk);
        load_req = 1'b1;
        load_val = v;
        stuck    = s;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        check({tag, " idle resp_valid"}, resp_valid, 0);
        check({tag, " idle cmd_ready"}, cmd_ready, 1);
        check({tag, " idle busy"}, busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int resp_cyc;
        int pulses;
        int consec;
        int max_consec;
        logic [WIDTH-1:0] j1;
        logic [WIDTH-1:0] k1;
        logic err_seen;
        string tag;
        tag = $sformatf("vec%0d", idx);
        load_bank(v.q0, v.stk);
        cmd_valid  = 1'b1;
        cmd_target = v.t;
        check({tag, " cmd_ready"}, cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        resp_cyc = 0; pulses = 0; consec = 0; max_consec = 0;
        j1 = '0; k1 = '0; err_seen = 1'b0;
        for (int c = 1; c <= 20 && resp_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin j1 = j; k1 = k; end
            if ((j | k) != '0) begin
                pulses++;
                consec++;
                if (consec > max_consec) max_consec = consec;
            end else begin
                consec = 0;
            end
            if (resp_valid) begin
                resp_cyc = c;
                err_seen = resp_err;
            end
        end
        check({tag, " j cycle1"}, j1, v.ej);
        check({tag, " k cycle1"}, k1, v.ek);
        check({tag, " resp cycle"}, resp_cyc, v.ecyc);
        check({tag, " resp_err"}, err_seen, v.eerr);
        check({tag, " drive pulses"}, pulses, v.epulses);
        check({tag, " max consecutive drive"}, max_consec, (v.epulses > 0) ? 1 : 0);
        handshake(tag);
    endtask

    task automatic run_rand(input int n);
        logic [WIDTH-1:0] q0, t, exp_t, ej, ek, qn;
        bit op, exp_err, done;
        int nf, dly;
        string tag;
        tag = $sformatf("rand%0d", n);
        q0 = WIDTH'($urandom);
        t  = WIDTH'($urandom);
        op = 1'b0;
`ifdef JK_TOGGLE_CMD_EN
        op = 1'($urandom_range(0, 1));
`endif
        nf  = $urandom_range(0, 3);
        dly = $urandom_range(0, 3);
        if (op) begin
            exp_t = q0 ^ t; ej = t; ek = t;
        end else begin
            exp_t = t; ej = ~q0 & t; ek = q0 & ~t;
        end
        load_bank(q0, 1'b0);
        cmd_valid  = 1'b1;
        cmd_target = t;
`ifdef JK_TOGGLE_CMD_EN
        cmd_op = op;
`endif
        @(posedge clk);
        #1 cmd_valid = 1'b0;
`ifdef JK_TOGGLE_CMD_EN
        cmd_op = 1'b0;
`endif
        exp_err = 1'b0;
        done    = 1'b0;
        for (int a = 0; a <= MAX_RETRY && !done; a++) begin
            @(negedge clk);
            check({tag, " drive j"}, j, ej);
            check({tag, " drive k"}, k, ek);
            check({tag, " drive busy"}, busy, 1);
            disturb = (a < nf) ? WIDTH'($urandom_range(1, 15)) : '0;
            @(posedge clk);
            #1 disturb = '0;
            @(negedge clk);
            check({tag, " check j idle"}, j, 0);
            check({tag, " check k idle"}, k, 0);
            check({tag, " check no resp"}, resp_valid, 0);
            qn = bank_q;
            if (qn == exp_t) begin
                exp_err = 1'b0; done = 1'b1;
            end else if (a == MAX_RETRY) begin
                exp_err = 1'b1; done = 1'b1;
            end else begin
                ej = ~qn & exp_t;
                ek = qn & ~exp_t;
            end
            @(posedge clk);
        end
        for (int d = 0; d <= dly; d++) begin
            @(negedge clk);
            check({tag, " resp_valid"}, resp_valid, 1);
            check({tag, " resp_err"}, resp_err, exp_err);
            check({tag, " cmd_ready in resp"}, cmd_ready, 0);
        end
        handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        // {q0, target, stuck, j, k, err, resp cycle, drive pulses}
        vecs[0] = '{4'b0000, 4'b1010, 1'b0, 4'b1010, 4'b0000, 1'b0, 3, 1};
        vecs[1] = '{4'b1111, 4'b0101, 1'b0, 4'b0000, 4'b1010, 1'b0, 3, 1};
        vecs[2] = '{4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 7, 3};
        vecs[3] = '{4'b0110, 4'b0110, 1'b0, 4'b0000, 4'b0000, 1'b0, 3, 0};
        vecs[4] = '{4'b1001, 4'b0110, 1'b1, 4'b0110, 4'b1001, 1'b1, 7, 3};
        vecs[5] = '{4'b0011, 4'b0101, 1'b0, 4'b0100, 4'b0010, 1'b0, 3, 1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_target = '0; resp_ready = 1'b0;
        load_req = 1'b0; load_val = '0; stuck = 1'b0; disturb = '0;
`ifdef JK_TOGGLE_CMD_EN
        cmd_op = 1'b0;
`endif
        #1;
        check("reset j", j, 0);
        check("reset k", k, 0);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_err", resp_err, 0);
        check("reset busy", busy, 0);
        check("reset cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Response stall: command held during RESP must not be accepted.
        load_bank(4'b0000, 1'b0);
        cmd_valid = 1'b1; cmd_target = 4'b0011;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stall first resp", resp_valid, 1);
        cmd_valid = 1'b1; cmd_target = 4'b1100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d resp_valid", c), resp_valid, 1);
            check($sformatf("stall%0d cmd_ready", c), cmd_ready, 0);
            check($sformatf("stall%0d j", c), j, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("stall release cmd_ready", cmd_ready, 1);
        check("stall release resp_valid", resp_valid, 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("held cmd j", j, 4'b1100);
        check("held cmd k", k, 4'b0011);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("held cmd resp", resp_valid, 1);
        check("held cmd err", resp_err, 0);
        handshake("held");

        // Asynchronous reset in the middle of a DRIVE cycle.
        load_bank(4'b1001, 1'b0);
        cmd_valid = 1'b1; cmd_target = 4'b1111;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("pre-rst j", j, 4'b0110);
        #2 rst = 1'b1;
        #1;
        check("async rst j", j, 0);
        check("async rst k", k, 0);
        check("async rst busy", busy, 0);
        check("async rst cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post rst idle resp_valid", resp_valid, 0);

`ifdef JK_TOGGLE_CMD_EN
        // Toggle command: 1100 ^ 0110 = 1010.
        load_bank(4'b1100, 1'b0);
        cmd_valid = 1'b1; cmd_target = 4'b0110; cmd_op = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0; cmd_op = 1'b0;
        @(negedge clk);
        check("toggle j", j, 4'b0110);
        check("toggle k", k, 4'b0110);
        @(negedge clk);
        check("toggle bank", bank_q, 4'b1010);
        @(negedge clk);
        check("toggle resp", resp_valid, 1);
        check("toggle err", resp_err, 0);
        handshake("toggle");
`endif

        for (int n = 0; n < 40; n++) run_rand(n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
